// File: rtl/cernbe_master_bridge_pkg.sv
// Shared types and constants for the cern-be-vme master bridge.
package cernbe_pkg;

  localparam int CERNBE_DATA_W = 32;
  localparam logic [CERNBE_DATA_W-1:0] CERNBE_ERR_DATA = 32'h0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    RESP    = 3'd3,
    DRAIN   = 3'd4
  } cernbe_state_t;

endpackage

// File: rtl/cernbe_master_bridge_if.sv
// Wishbone slave port plus cern-be-vme strobe/done bus seen by the bridge.
// slave: the bridge's view. master: the surrounding system (Wishbone master
// and memory-map decoder).
interface cernbe_master_bridge_if
  import cernbe_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
);
  logic                     wb_cyc_i;
  logic                     wb_stb_i;
  logic                     wb_we_i;
  logic [ADDR_WIDTH-1:2]    wb_adr_i;
  logic [CERNBE_DATA_W-1:0] wb_dat_i;
  logic [CERNBE_DATA_W-1:0] wb_dat_o;
  logic                     wb_ack_o;
  logic                     wb_err_o;
  logic [ADDR_WIDTH-1:2]    vme_addr_o;
  logic [CERNBE_DATA_W-1:0] vme_wr_data_o;
  logic                     vme_rd_mem_o;
  logic                     vme_wr_mem_o;
  logic [CERNBE_DATA_W-1:0] vme_rd_data_i;
  logic                     vme_rd_done_i;
  logic                     vme_wr_done_i;
  logic                     vme_rd_error_i;
  logic                     vme_wr_error_i;
  logic                     busy_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output vme_addr_o, vme_wr_data_o, vme_rd_mem_o, vme_wr_mem_o,
    input  vme_rd_data_i, vme_rd_done_i, vme_wr_done_i,
    input  vme_rd_error_i, vme_wr_error_i,
    output busy_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  vme_addr_o, vme_wr_data_o, vme_rd_mem_o, vme_wr_mem_o,
    output vme_rd_data_i, vme_rd_done_i, vme_wr_done_i,
    output vme_rd_error_i, vme_wr_error_i,
    input  busy_o
  );
endinterface

// File: rtl/cernbe_master_bridge_wait_timer.sv
// Wait-state counter for the bridge watchdog: cleared by clr, counts up while
// en, saturates at LIMIT and flags expired there.
module cernbe_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Count wait cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(LIMIT));
endmodule

// File: rtl/cernbe_master_bridge.sv
// Wishbone classic slave -> cern-be-vme strobe/done master bridge.
// One transfer in flight; each request becomes exactly one RdMem/WrMem pulse,
// and the decoder's Done/Error comes back as a one-cycle ack/err.
// Build option: define CERNBE_BRIDGE_TIMEOUT_EN to add the watchdog and the
// DRAIN state that absorbs the late answer of a timed-out transfer.
//
// state   | meaning
// IDLE    | no transfer; a cyc&stb sample starts one
// RD_WAIT | read strobed, waiting for rd done/error (or timeout)
// WR_WAIT | write strobed, waiting for wr done/error (or timeout)
// RESP    | one-cycle ack/err presented to the Wishbone master
// DRAIN   | after a timeout: swallow the late answer, bounded by the watchdog
module cernbe_master_bridge
  import cernbe_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  cernbe_master_bridge_if.slave bus
);
  cernbe_state_t state, stateNext;

  logic accept, complete, failed;
  logic wrSel, doneIn, errIn, expired;

  logic [ADDR_WIDTH-1:2]    addrQ;
  logic [CERNBE_DATA_W-1:0] wrDataQ;
  logic [CERNBE_DATA_W-1:0] rdDataQ;
  logic                     rdMemQ, wrMemQ, ackQ, errQ;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : gBadTimeout
    $error("cernbe_master_bridge: TIMEOUT_CYCLES must be 1..65535");
  end

`ifdef CERNBE_BRIDGE_TIMEOUT_EN
  logic timerClr, timerEn, drainWr, timedOut;

  // The same counter times the WAIT phase and then the DRAIN phase.
  assign timerClr = (state == IDLE) || (state == RESP);
  assign timerEn  = (state == RD_WAIT) || (state == WR_WAIT) || (state == DRAIN);
  assign wrSel    = (state == WR_WAIT) || ((state == DRAIN) && drainWr);

  cernbe_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timerClr),
    .en      (timerEn),
    .expired (expired)
  );

  // Remember the direction and the timeout cause for the DRAIN phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drainWr  <= 1'b0;
      timedOut <= 1'b0;
    end else begin
      timedOut <= complete && bus.wb_cyc_i && !doneIn && !errIn;
      if (complete) drainWr <= wrSel;
    end
  end
`else
  assign expired = 1'b0;
  assign wrSel   = (state == WR_WAIT);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state and transfer events; only the matching direction completes.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    complete  = 1'b0;
    failed    = 1'b0;
    doneIn    = wrSel ? bus.vme_wr_done_i  : bus.vme_rd_done_i;
    errIn     = wrSel ? bus.vme_wr_error_i : bus.vme_rd_error_i;
    case (state)
      IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          accept    = 1'b1;
          stateNext = bus.wb_we_i ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (doneIn || errIn || expired) begin
          complete  = 1'b1;
          failed    = errIn || !doneIn;
          stateNext = bus.wb_cyc_i ? RESP : IDLE;
        end
      end
      RESP: begin
`ifdef CERNBE_BRIDGE_TIMEOUT_EN
        stateNext = timedOut ? DRAIN : IDLE;
`else
        stateNext = IDLE;
`endif
      end
      DRAIN: begin
        if (doneIn || errIn || expired) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Registered strobes, responses, held address/data and read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdMemQ  <= 1'b0;
      wrMemQ  <= 1'b0;
      ackQ    <= 1'b0;
      errQ    <= 1'b0;
      addrQ   <= '0;
      wrDataQ <= '0;
      rdDataQ <= '0;
    end else begin
      rdMemQ <= accept && !bus.wb_we_i;
      wrMemQ <= accept && bus.wb_we_i;
      ackQ   <= complete && bus.wb_cyc_i && !failed;
      errQ   <= complete && bus.wb_cyc_i && failed;
      if (accept) begin
        addrQ   <= bus.wb_adr_i;
        wrDataQ <= bus.wb_dat_i;
      end
      if (complete && failed)      rdDataQ <= CERNBE_ERR_DATA;
      else if (complete && !wrSel) rdDataQ <= bus.vme_rd_data_i;
    end
  end

  assign bus.vme_rd_mem_o  = rdMemQ;
  assign bus.vme_wr_mem_o  = wrMemQ;
  assign bus.vme_addr_o    = addrQ;
  assign bus.vme_wr_data_o = wrDataQ;
  assign bus.wb_ack_o      = ackQ;
  assign bus.wb_err_o      = errQ;
  assign bus.wb_dat_o      = rdDataQ;
  assign bus.busy_o        = (state != IDLE);
endmodule
